// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run controller for the pipelined RISC-V core.
// Holds the core in reset for RESET_CYCLES after a start pulse, then lets it
// run for at most MAX_CYCLES while watching core_out for PASS_VALUE.
// Reports pass or timeout together with the number of RUN cycles used.
// Optional trace FIFO of {cycle_count, core_out} changes: define
// CORE_RUN_TRACE_EN to build it; without it the trace outputs are tied to 0.
module core_run_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 100,
  parameter logic [XLEN-1:0] PASS_VALUE   = XLEN'(32'h0000_0001),
  parameter int              CNT_W        = 16,
  parameter int              TRACE_DEPTH  = 8
) (
  input  logic                  clk_signal,
  input  logic                  reset,
  input  logic                  start,
  input  logic [XLEN-1:0]       core_out,
  output logic                  core_reset,
  output logic                  run_en,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [XLEN-1:0]       last_out,
  input  logic                  trace_rd_en,
  output logic                  trace_valid,
  output logic [CNT_W+XLEN-1:0] trace_data,
  output logic                  trace_ovf
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, DONE} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;

  // Run sequencer: state and every status output updated together.
  // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_signal) begin
    if (reset) begin
      state       <= IDLE;
      core_reset  <= 1'b1;
      run_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      last_out    <= '0;
      hold_cnt    <= '0;
    end else if (start) begin
      // A start from any state (re)enters the reset hold with clean status.
      state       <= RST_HOLD;
      core_reset  <= 1'b1;
      run_en      <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      last_out    <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
        end
        RST_HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            run_en     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          last_out <= core_out;
          if (core_out == PASS_VALUE) begin
            // Pass is checked first so it wins over budget exhaustion.
            state      <= DONE;
            core_reset <= 1'b1;
            run_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b1;
          end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            state      <= DONE;
            core_reset <= 1'b1;
            run_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CORE_RUN_TRACE_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);

  logic [CNT_W+XLEN-1:0] trace_mem [TRACE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        fill;
  logic                  push_req;
  logic                  do_push;
  logic                  do_pop;

  // A start in the same cycle clears the FIFO, so it suppresses the push.
  assign push_req = (state == RUN) && !start &&
                    ((cycle_count == '0) || (core_out != last_out));
  assign do_pop   = trace_rd_en && (fill != '0);
  assign do_push  = push_req && ((fill != (PTR_W+1)'(TRACE_DEPTH)) || do_pop);

  // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_signal) begin
    if (reset || start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      trace_ovf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      if (push_req && !do_push) trace_ovf <= 1'b1;
    end
  end

  // Trace storage write port.
  // NOTE: the array has no reset; only pointers matter, and this keeps it RAM-mappable.
  always_ff @(posedge clk_signal) begin
    if (do_push) trace_mem[wr_ptr] <= {cycle_count, core_out};
  end

  assign trace_valid = (fill != '0);
  assign trace_data  = trace_valid ? trace_mem[rd_ptr] : '0;
`else
  logic unused_trace;

  assign unused_trace = trace_rd_en & (TRACE_DEPTH > 1);
  assign trace_valid  = 1'b0;
  assign trace_data   = '0;
  assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus a timeline model that
// derives the expected outputs from the recorded start/reset/core_out history.
module tb_core_run_ctrl;

  localparam int              XLEN         = 32;
  localparam int              RESET_CYCLES = 2;
  localparam int              MAX_CYCLES   = 10;
  localparam logic [XLEN-1:0] PASS_VALUE   = 32'h0000_0001;
  localparam int              CNT_W        = 16;
  localparam int              TRACE_DEPTH  = 4;
  localparam int              HIST         = 4096;

  logic                  clk_signal = 1'b0;
  logic                  reset;
  logic                  start;
  logic [XLEN-1:0]       core_out;
  logic                  core_reset;
  logic                  run_en;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic                  timeout;
  logic [CNT_W-1:0]      cycle_count;
  logic [XLEN-1:0]       last_out;
  logic                  trace_rd_en;
  logic                  trace_valid;
  logic [CNT_W+XLEN-1:0] trace_data;
  logic                  trace_ovf;

  int n_checks = 0;
  int n_errors = 0;

  core_run_ctrl #(
    .XLEN(XLEN), .RESET_CYCLES(RESET_CYCLES), .MAX_CYCLES(MAX_CYCLES),
    .PASS_VALUE(PASS_VALUE), .CNT_W(CNT_W), .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .clk_signal(clk_signal), .reset(reset), .start(start), .core_out(core_out),
    .core_reset(core_reset), .run_en(run_en), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .cycle_count(cycle_count),
    .last_out(last_out), .trace_rd_en(trace_rd_en), .trace_valid(trace_valid),
    .trace_data(trace_data), .trace_ovf(trace_ovf)
  );

  always #5 clk_signal = ~clk_signal;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Input history, one entry per rising edge.
  logic            rst_h   [HIST];
  logic            start_h [HIST];
  logic [XLEN-1:0] core_h  [HIST];
  int              n_edges = 0;

  always @(posedge clk_signal) begin
    if (n_edges < HIST) begin
      rst_h[n_edges]   = reset;
      start_h[n_edges] = start;
      core_h[n_edges]  = core_out;
      n_edges++;
    end
  end

  typedef struct packed {
    logic             valid;
    logic             core_reset;
    logic             run_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  last;
  } exp_t;

  // Expected outputs after edge n: find the latest start/reset, then walk
  // the run window that follows it.
  function automatic exp_t model(int n);
    exp_t e;
    int   l;
    int   r0;
    int   k_end;
    int   m;
    e            = '0;
    e.core_reset = 1'b1;
    l            = -1;
    for (int i = n; i >= 0; i--) begin
      if (rst_h[i] || start_h[i]) begin
        l = i;
        break;
      end
    end
    if (l < 0) return e;
    e.valid = 1'b1;
    if (rst_h[l]) return e;
    if (n - l < RESET_CYCLES) begin
      e.busy = 1'b1;
      return e;
    end
    r0    = l + RESET_CYCLES + 1;
    k_end = -1;
    for (int k = 0; r0 + k <= n; k++) begin
      if (core_h[r0+k] == PASS_VALUE) begin
        k_end  = k;
        e.pass = 1'b1;
        break;
      end
      if (k == MAX_CYCLES - 1) begin
        k_end     = k;
        e.timeout = 1'b1;
        break;
      end
    end
    if (k_end >= 0) begin
      e.done = 1'b1;
      e.cnt  = CNT_W'(k_end);
      e.last = core_h[r0+k_end];
      return e;
    end
    m            = n - r0 + 1;
    e.core_reset = 1'b0;
    e.run_en     = 1'b1;
    e.busy       = 1'b1;
    e.cnt        = CNT_W'(m);
    e.last       = (m > 0) ? core_h[r0+m-1] : '0;
    return e;
  endfunction

  exp_t cur;

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk_signal) begin
    if (n_edges > 0) begin
      cur = model(n_edges - 1);
      if (cur.valid) begin
        check("m_core_reset", 64'(core_reset), 64'(cur.core_reset));
        check("m_run_en", 64'(run_en), 64'(cur.run_en));
        check("m_busy", 64'(busy), 64'(cur.busy));
        check("m_done", 64'(done), 64'(cur.done));
        check("m_pass", 64'(pass), 64'(cur.pass));
        check("m_timeout", 64'(timeout), 64'(cur.timeout));
        check("m_cycle_count", 64'(cycle_count), 64'(cur.cnt));
        check("m_last_out", 64'(last_out), 64'(cur.last));
`ifndef CORE_RUN_TRACE_EN
        check("m_trace_valid", 64'(trace_valid), 64'd0);
        check("m_trace_data", 64'(trace_data), 64'd0);
        check("m_trace_ovf", 64'(trace_ovf), 64'd0);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk_signal);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) step();
    check("done_reached", 64'(done), 64'd1);
  endtask

  int                    tr_vals [7] = '{0, 0, 3, 3, 7, 9, 2};
  logic [CNT_W+XLEN-1:0] tr_exp  [4];

  initial begin
    tr_exp[0] = {16'd0, 32'd0};
    tr_exp[1] = {16'd2, 32'd3};
    tr_exp[2] = {16'd4, 32'd7};
    tr_exp[3] = {16'd5, 32'd9};

    reset       = 1'b1;
    start       = 1'b0;
    core_out    = '0;
    trace_rd_en = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("idle_core_reset", 64'(core_reset), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_cycle_count", 64'(cycle_count), 64'd0);

    // Reset hold then pass after four zero cycles.
    pulse_start();
    check("hold1_core_reset", 64'(core_reset), 64'd1);
    check("hold1_run_en", 64'(run_en), 64'd0);
    step();
    check("hold2_core_reset", 64'(core_reset), 64'd1);
    step();
    check("run0_run_en", 64'(run_en), 64'd1);
    check("run0_core_reset", 64'(core_reset), 64'd0);
    check("run0_cycle_count", 64'(cycle_count), 64'd0);
    repeat (4) step();
    core_out = 32'd1;
    step();
    check("pass_done", 64'(done), 64'd1);
    check("pass_pass", 64'(pass), 64'd1);
    check("pass_timeout", 64'(timeout), 64'd0);
    check("pass_cycle_count", 64'(cycle_count), 64'd4);
    check("pass_last_out", 64'(last_out), 64'd1);
    check("pass_core_reset", 64'(core_reset), 64'd1);

    // Budget exhaustion.
    core_out = 32'd5;
    pulse_start();
    wait_done(40);
    check("to_timeout", 64'(timeout), 64'd1);
    check("to_pass", 64'(pass), 64'd0);
    check("to_cycle_count", 64'(cycle_count), 64'd9);
    repeat (3) step();
    check("to_hold_count", 64'(cycle_count), 64'd9);

    // Pass exactly on the last budget cycle.
    pulse_start();
    repeat (2) step();
    repeat (MAX_CYCLES - 1) step();
    core_out = PASS_VALUE;
    step();
    check("edge_pass", 64'(pass), 64'd1);
    check("edge_timeout", 64'(timeout), 64'd0);
    check("edge_cycle_count", 64'(cycle_count), 64'd9);

    // Abort mid-run with start, then reset mid-run.
    core_out = 32'd100;
    pulse_start();
    repeat (2) step();
    for (int i = 0; i < 5; i++) begin
      core_out = 32'(100 + i);
      step();
    end
    check("abort_pre_count", 64'(cycle_count), 64'd5);
    pulse_start();
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_run_en", 64'(run_en), 64'd0);
    check("abort_pass", 64'(pass), 64'd0);
    check("abort_count", 64'(cycle_count), 64'd0);
    repeat (2) step();
    check("rerun_run_en", 64'(run_en), 64'd1);
    check("rerun_count", 64'(cycle_count), 64'd0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_count", 64'(cycle_count), 64'd0);

    // Trace sequence: 0,0,3,3,7,9,2 into a 4-entry FIFO.
    pulse_start();
    repeat (2) step();
    for (int i = 0; i < 7; i++) begin
      core_out = 32'(tr_vals[i]);
      step();
    end
`ifdef CORE_RUN_TRACE_EN
    check("tr_ovf", 64'(trace_ovf), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("tr_valid", 64'(trace_valid), 64'd1);
      check("tr_head", 64'(trace_data), 64'(tr_exp[i]));
      trace_rd_en = 1'b1;
      step();
    end
    trace_rd_en = 1'b0;
    check("tr_empty", 64'(trace_valid), 64'd0);
    trace_rd_en = 1'b1;
    step();
    trace_rd_en = 1'b0;
    check("tr_empty_pop", 64'(trace_valid), 64'd0);
    wait_done(20);
    pulse_start();
    check("tr_ovf_clear", 64'(trace_ovf), 64'd0);
`else
    check("notr_valid", 64'(trace_valid), 64'd0);
    check("notr_ovf", 64'(trace_ovf), 64'd0);
    trace_rd_en = 1'b1;
    repeat (4) step();
    trace_rd_en = 1'b0;
    check("notr_valid_pop", 64'(trace_valid), 64'd0);
    wait_done(20);
`endif
    check("final_done", 64'(done), 64'd1);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Synthesizable run controller for the pipelined RISC-V core. Generalises bench-style reset/run/finish sequencing into parametrised on-FPGA hardware.
- Generates the core reset and sequences a multi-cycle reset hold, then a bounded run.
- Watches the core result bus for a pass signature and reports pass or timeout with a cycle count.
- Sits between board-level start logic and TOP. Drives TOP's reset input; samples TOP's out_1.

Parameters:
- XLEN, 32, width of the monitored core result bus.
- RESET_CYCLES, 2, cycles core_reset is held high after start (>=1).
- MAX_CYCLES, 100, run-cycle budget before timeout (>=1).
- PASS_VALUE, 32'h0000_0001, core_out value that signals a passing program.
- CNT_W, 16, width of cycle_count (must hold MAX_CYCLES-1).
- TRACE_DEPTH, 8, trace FIFO entries (power of 2, >=2; only used with the optional feature).

Ports:
- clk_signal  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset of this block.
- start  in  1  single-cycle pulse; starts or restarts a run.
- core_out  in  XLEN  core result bus (TOP out_1).
- core_reset  out  1  reset driven into TOP.
- run_en  out  1  high while the core is in the bounded run window.
- busy  out  1  high in RST_HOLD or RUN.
- done  out  1  high in DONE.
- pass  out  1  run ended on PASS_VALUE; valid while done.
- timeout  out  1  run ended on budget exhaustion; valid while done.
- cycle_count  out  CNT_W  RUN cycles elapsed; frozen in DONE.
- last_out  out  XLEN  core_out registered every RUN cycle.
- trace_rd_en  in  1  pop the trace FIFO head.
- trace_valid  out  1  trace FIFO non-empty.
- trace_data  out  CNT_W+XLEN  head entry as {cycle_count, core_out}.
- trace_ovf  out  1  sticky flag: a trace entry was dropped.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, core_reset=1.
  - run_en, busy, done, pass, timeout, trace_valid, trace_ovf = 0.
  - cycle_count, last_out, trace_data = 0.
- States: IDLE, RST_HOLD, RUN, DONE. All outputs are registered.
- IDLE:
  - core_reset=1.
  - start=1 -> RST_HOLD next cycle; clears pass, timeout, cycle_count and last_out.
- RST_HOLD:
  - core_reset=1, busy=1.
  - Internal counter counts RESET_CYCLES cycles, then -> RUN.
  - start asserted in RST_HOLD: counter restarts from 0.
- RUN:
  - core_reset=0, run_en=1, busy=1.
  - cycle_count is 0 on the first RUN cycle and increments by 1 each cycle.
  - last_out <= core_out every cycle.
  - core_out==PASS_VALUE -> DONE with pass=1.
  - Else cycle_count==MAX_CYCLES-1 -> DONE with timeout=1.
  - Pass and budget end on the same cycle: pass wins, timeout=0.
  - The sampling cycle is counted. Pass on the first RUN cycle gives cycle_count=0 in DONE.
- DONE:
  - done=1, run_en=0, core_reset=1 (core frozen).
  - cycle_count and last_out hold.
  - start -> RST_HOLD, same clears as from IDLE.
- start in RUN: abort, -> RST_HOLD, pass/timeout stay 0.
- reset mid-run: immediate return to IDLE on the next edge; no done or pass pulse is generated.
- Outputs never show pass and timeout both at 1.

Optional Feature:
- Macro: CORE_RUN_TRACE_EN.
- Defined: trace FIFO of TRACE_DEPTH entries.
  - Push rule: in RUN, push {cycle_count, core_out} on the first RUN cycle and on every cycle where core_out differs from last_out.
  - Read side is first-word-fall-through: trace_data shows the head whenever trace_valid=1; trace_rd_en pops.
  - trace_rd_en while empty: ignored.
  - Push while full: entry dropped, trace_ovf set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - Pointers wrap modulo TRACE_DEPTH.
  - FIFO and trace_ovf clear on reset and on start.
- Undefined:
  - No FIFO storage is built.
  - trace_valid=0, trace_data=0, trace_ovf=0 constantly.
  - trace_rd_en is ignored.
  - Port list is unchanged.

Test Plan:
- Reset then start at cycle 0, RESET_CYCLES=2 -> core_reset high through cycle 2, run_en rises at cycle 3 with cycle_count=0.
- core_out=0 for 4 RUN cycles, then 1 -> done=1, pass=1, timeout=0, cycle_count=4, last_out=1, core_reset=1.
- MAX_CYCLES=10, core_out never 1 -> timeout=1 after RUN cycle 9, cycle_count=9, pass=0.
- PASS_VALUE appears exactly on RUN cycle MAX_CYCLES-1 -> pass=1, timeout=0.
- start pulse mid-RUN at cycle_count=5 -> back to RST_HOLD; new run starts at cycle_count=0. reset mid-RUN -> IDLE next edge, all status 0.
- With CORE_RUN_TRACE_EN, TRACE_DEPTH=4:
  - core_out sequence 0,0,3,3,7,9,2 -> entries {0,0},{2,3},{4,7},{5,9}; cycle-6 entry dropped; trace_ovf=1.
  - Pop 4 times -> trace_valid=0.
  - Without the macro -> trace_valid stays 0.
